// File: rtl/exe_muldiv_stage_if.sv
// rtl/exe_muldiv_stage_if.sv - ID/EXE to EXE/MEM signal bundle for the EXE mul/div stage
interface exe_muldiv_stage_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] OperandA_IN;
    logic [WIDTH-1:0] OperandB_IN;
    logic [5:0]       ALUControl_IN;
    logic [4:0]       ShiftAmount_IN;
    logic [WIDTH-1:0] MemWriteData_IN;
    logic             MemRead_IN;
    logic             MemWrite_IN;
    logic [4:0]       WriteRegister_IN;
    logic             WriteEnable_IN;
    logic [WIDTH-1:0] ALUResult_OUT;
    logic [WIDTH-1:0] MemWriteData_OUT;
    logic             MemRead_OUT;
    logic             MemWrite_OUT;
    logic [4:0]       WriteRegister_OUT;
    logic             WriteEnable_OUT;
    logic             STALL_OUT;
    logic             MDBusy_OUT;
    logic             Overflow_OUT;

    modport master (
        output OperandA_IN, OperandB_IN, ALUControl_IN, ShiftAmount_IN, MemWriteData_IN,
               MemRead_IN, MemWrite_IN, WriteRegister_IN, WriteEnable_IN,
        input  ALUResult_OUT, MemWriteData_OUT, MemRead_OUT, MemWrite_OUT, WriteRegister_OUT,
               WriteEnable_OUT, STALL_OUT, MDBusy_OUT, Overflow_OUT
    );

    modport slave (
        input  OperandA_IN, OperandB_IN, ALUControl_IN, ShiftAmount_IN, MemWriteData_IN,
               MemRead_IN, MemWrite_IN, WriteRegister_IN, WriteEnable_IN,
        output ALUResult_OUT, MemWriteData_OUT, MemRead_OUT, MemWrite_OUT, WriteRegister_OUT,
               WriteEnable_OUT, STALL_OUT, MDBusy_OUT, Overflow_OUT
    );
endinterface

// File: rtl/exe_muldiv_stage.sv
// rtl/exe_muldiv_stage.sv - MIPS EXE stage: single-cycle ALU plus iterative mul/div unit owning HI/LO
module exe_muldiv_stage #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] HILO_INIT = '0
) (
    input logic                CLOCK,
    input logic                RESET,
    exe_muldiv_stage_if.slave  bus
);
    localparam logic [5:0] OP_SLL  = 6'h00, OP_SRL  = 6'h02, OP_SRA  = 6'h03, OP_SLLV = 6'h04;
    localparam logic [5:0] OP_SRLV = 6'h06, OP_SRAV = 6'h07, OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_MFHI = 6'h10, OP_MTHI = 6'h11, OP_MFLO = 6'h12, OP_MTLO = 6'h13;
    localparam logic [5:0] OP_MULT = 6'h18, OP_MULTU = 6'h19, OP_DIV = 6'h1A, OP_DIVU = 6'h1B;
    localparam logic [5:0] OP_ADD  = 6'h20, OP_ADDU = 6'h21, OP_SUB  = 6'h22, OP_SUBU = 6'h23;
    localparam logic [5:0] OP_AND  = 6'h24, OP_OR   = 6'h25, OP_XOR  = 6'h26, OP_NOR  = 6'h27;
    localparam logic [5:0] OP_SLT  = 6'h2A, OP_SLTU = 6'h2B;
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} mdState_t;

    mdState_t         state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hiReg, loReg;
    logic [WIDTH-1:0] accHi, accLo, opB, origA;
    logic             isDivOp, negQ, negR, divZero;

    logic [WIDTH-1:0] a, b, addSum, subDiff, aluResult;
    logic [5:0]       op;
    logic             overflow, isMulDivOp, isHiLoOp, isSignedOp, signA, signB, mdBusy, stall;
    logic [WIDTH-1:0] magA, magB;

    assign a       = bus.OperandA_IN;
    assign b       = bus.OperandB_IN;
    assign op      = bus.ALUControl_IN;
    assign addSum  = a + b;
    assign subDiff = a - b;

    always_comb begin
        aluResult = '0;
        overflow  = 1'b0;
        case (op)
            OP_SLL:  aluResult = b << bus.ShiftAmount_IN;
            OP_SRL:  aluResult = b >> bus.ShiftAmount_IN;
            OP_SRA:  aluResult = $signed(b) >>> bus.ShiftAmount_IN;
            OP_SLLV: aluResult = b << a[4:0];
            OP_SRLV: aluResult = b >> a[4:0];
            OP_SRAV: aluResult = $signed(b) >>> a[4:0];
            OP_LUI:  aluResult = b << 16;
            OP_MFHI: aluResult = hiReg;
            OP_MFLO: aluResult = loReg;
            OP_ADD: begin
                aluResult = addSum;
                overflow  = (a[WIDTH-1] == b[WIDTH-1]) && (addSum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_ADDU: aluResult = addSum;
            OP_SUB: begin
                aluResult = subDiff;
                overflow  = (a[WIDTH-1] != b[WIDTH-1]) && (subDiff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUBU: aluResult = subDiff;
            OP_AND:  aluResult = a & b;
            OP_OR:   aluResult = a | b;
            OP_XOR:  aluResult = a ^ b;
            OP_NOR:  aluResult = ~(a | b);
            OP_SLT:  aluResult = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: aluResult = {{(WIDTH-1){1'b0}}, (a < b)};
            default: aluResult = '0;
        endcase
    end

    assign isMulDivOp = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    assign isHiLoOp   = isMulDivOp || (op == OP_MFHI) || (op == OP_MFLO) ||
                        (op == OP_MTHI) || (op == OP_MTLO);
    assign isSignedOp = (op == OP_MULT) || (op == OP_DIV);
    assign signA      = isSignedOp & a[WIDTH-1];
    assign signB      = isSignedOp & b[WIDTH-1];
    assign magA       = signA ? -a : a;
    assign magB       = signB ? -b : b;
    assign mdBusy     = (state != IDLE);
    assign stall      = mdBusy & isHiLoOp;

    // Multiply: accLo holds the multiplier and shifts out; product grows into {accHi,accLo}.
    // Divide: {accHi,accLo} is the restoring remainder/dividend pair; quotient bits enter accLo.
    logic [WIDTH:0]     mulSum, divShift;
    logic [WIDTH-1:0]   divDiff;
    logic               divGe;
    logic [2*WIDTH-1:0] product, productFix;
    logic [WIDTH-1:0]   fixHi, fixLo;

    assign mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opB} : '0);
    assign divShift = {accHi, accLo[WIDTH-1]};
    assign divGe    = divShift >= {1'b0, opB};
    assign divDiff  = divShift[WIDTH-1:0] - opB;
    assign product  = {accHi, accLo};
    assign productFix = negQ ? -product : product;

    always_comb begin
        fixHi = productFix[2*WIDTH-1:WIDTH];
        fixLo = productFix[WIDTH-1:0];
        if (isDivOp) begin
            if (divZero) begin
                fixHi = origA;
                fixLo = '1;
            end else begin
                fixHi = negR ? -accHi : accHi;
                fixLo = negQ ? -accLo : accLo;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state   <= IDLE;
            cnt     <= '0;
            hiReg   <= HILO_INIT;
            loReg   <= HILO_INIT;
            accHi   <= '0;
            accLo   <= '0;
            opB     <= '0;
            origA   <= '0;
            isDivOp <= 1'b0;
            negQ    <= 1'b0;
            negR    <= 1'b0;
            divZero <= 1'b0;
        end else begin
            if (!stall && op == OP_MTHI) hiReg <= a;
            if (!stall && op == OP_MTLO) loReg <= a;
            // FIX writes come after the MTHI/MTLO writes so the FSM result wins on a shared edge.
            case (state)
                IDLE: begin
                    if (isMulDivOp && !stall) begin
                        state   <= RUN;
                        cnt     <= '0;
                        accHi   <= '0;
                        accLo   <= magA;
                        opB     <= magB;
                        origA   <= a;
                        isDivOp <= (op == OP_DIV) || (op == OP_DIVU);
                        negQ    <= signA ^ signB;
                        negR    <= signA;
                        divZero <= (b == '0);
                    end
                end
                RUN: begin
                    if (isDivOp) begin
                        accHi <= divGe ? divDiff : divShift[WIDTH-1:0];
                        accLo <= {accLo[WIDTH-2:0], divGe};
                    end else begin
                        accHi <= mulSum[WIDTH:1];
                        accLo <= {mulSum[0], accLo[WIDTH-1:1]};
                    end
                    if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
                    else                          cnt   <= cnt + 1'b1;
                end
                FIX: begin
                    hiReg <= fixHi;
                    loReg <= fixLo;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ALUResult_OUT     = aluResult;
    assign bus.Overflow_OUT      = overflow;
    assign bus.MemWriteData_OUT  = bus.MemWriteData_IN;
    assign bus.WriteRegister_OUT = bus.WriteRegister_IN;
    assign bus.MemRead_OUT       = bus.MemRead_IN & ~stall;
    assign bus.MemWrite_OUT      = bus.MemWrite_IN & ~stall;
    assign bus.WriteEnable_OUT   = bus.WriteEnable_IN & ~stall & ~overflow;
    assign bus.STALL_OUT         = stall;
    assign bus.MDBusy_OUT        = mdBusy;
endmodule
